// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank
//   Bank of WIDTH independent asynchronous inputs brought into the clk domain.
//   Each channel has a STAGES-deep synchroniser chain, an optional stable-count
//   debounce filter and registered rise/fall pulse generation.
//
//   Build option: define SYNC_DEBOUNCE_EN to include the debounce counters and
//   their per-channel FSM. Without it, q follows the synchroniser output every
//   edge and DB_CYCLES has no effect.
//
// Parameters
//   WIDTH     number of channels
//   STAGES    synchroniser flops per channel (>= 2)
//   DB_CYCLES stable cycles required before q follows the synchronised value (>= 1)
//   RST_VAL   reset value of the sync chain and q
//
// Ports
//   clk     clock, all state on the rising edge
//   rst     asynchronous active-low reset
//   d       raw asynchronous inputs
//   q       synchronised (and debounced) level
//   rise    one-cycle pulse on a 0->1 transition of q
//   fall    one-cycle pulse on a 1->0 transition of q
//   change  OR of all rise/fall bits, aligned with them
module sync_debounce_bank #(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 2,
    parameter int               DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             change
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_debounce_bank: STAGES must be at least 2");
    end

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("sync_debounce_bank: DB_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser chain: plain shift register, nothing between the flops
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_r[i] <= RST_VAL;
            end
        end else begin
            sync_r[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign s = sync_r[STAGES-1];

    // Next value of q, produced by either the debounce filter or straight
    // from the synchroniser.
    logic [WIDTH-1:0] q_nxt;

`ifdef SYNC_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debounce filter: per channel, q only follows s once s has differed
    // from q on DB_CYCLES consecutive edges.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

    db_state_t       state_r   [WIDTH];
    db_state_t       state_nxt [WIDTH];
    logic [CW-1:0]   cnt_r     [WIDTH];
    logic [CW-1:0]   cnt_nxt   [WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_r[i] <= state_nxt[i];
                cnt_r[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        q_nxt = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state_r[i];
            cnt_nxt[i]   = cnt_r[i];
            case (state_r[i])
                IDLE: begin
                    cnt_nxt[i] = '0;
                    if (s[i] != q[i]) begin
                        // The first differing edge is count 0; with a
                        // one-cycle filter that edge already commits.
                        if (DB_CYCLES == 1) begin
                            q_nxt[i] = s[i];
                        end else begin
                            cnt_nxt[i]   = CW'(1);
                            state_nxt[i] = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (s[i] == q[i]) begin
                        // Input returned before the window closed: glitch.
                        cnt_nxt[i]   = '0;
                        state_nxt[i] = IDLE;
                    end else if (cnt_r[i] == CW'(DB_CYCLES - 1)) begin
                        q_nxt[i]     = s[i];
                        cnt_nxt[i]   = '0;
                        state_nxt[i] = IDLE;
                    end else begin
                        cnt_nxt[i] = cnt_r[i] + CW'(1);
                    end
                end
                default: begin
                    cnt_nxt[i]   = '0;
                    state_nxt[i] = IDLE;
                end
            endcase
        end
    end
`else
    // No filtering: q is one more register stage behind the synchroniser.
    always_comb begin
        q_nxt = s;
    end
`endif

    // ------------------------------------------------------------------
    // Output level and edge pulses.
    // The q register doubles as the edge-detect history: the pulses are
    // computed from q_nxt against the current q, so the registered
    // rise/fall equal q & ~q_prev in the very cycle q changes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= RST_VAL;
            rise   <= '0;
            fall   <= '0;
            change <= 1'b0;
        end else begin
            q      <= q_nxt;
            rise   <= q_nxt & ~q;
            fall   <= ~q_nxt & q;
            change <= |(q_nxt ^ q);
        end
    end

endmodule

// File: tb/tb_sync_debounce_bank.sv
module tb_sync_debounce_bank;

`ifdef SYNC_DEBOUNCE_EN
    localparam int L = 6;   // STAGES + DB_CYCLES
`else
    localparam int L = 3;   // STAGES + 1
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d   = 4'h0;
    logic [3:0] d1  = 4'h0;

    logic [3:0] q0, rise0, fall0;
    logic       change0;
    logic [3:0] q1, rise1, fall1;
    logic       change1;

    int unsigned cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned cyc;
        bit          which;
        string       name;
        logic [3:0]  q;
        logic [3:0]  r;
        logic [3:0]  f;
        logic        ch;
    } exp_t;

    exp_t sb[$];

    sync_debounce_bank #(
        .WIDTH     (4),
        .STAGES    (2),
        .DB_CYCLES (4),
        .RST_VAL   (4'h0)
    ) dut0 (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .q      (q0),
        .rise   (rise0),
        .fall   (fall0),
        .change (change0)
    );

    sync_debounce_bank #(
        .WIDTH     (4),
        .STAGES    (2),
        .DB_CYCLES (4),
        .RST_VAL   (4'hA)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .d      (d1),
        .q      (q1),
        .rise   (rise1),
        .fall   (fall1),
        .change (change1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: compares every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
            end else if (e.which) begin
                chk({e.name, ".q"},      q1,              e.q);
                chk({e.name, ".rise"},   rise1,           e.r);
                chk({e.name, ".fall"},   fall1,           e.f);
                chk({e.name, ".change"}, {3'b000, change1}, {3'b000, e.ch});
            end else begin
                chk({e.name, ".q"},      q0,              e.q);
                chk({e.name, ".rise"},   rise0,           e.r);
                chk({e.name, ".fall"},   fall0,           e.f);
                chk({e.name, ".change"}, {3'b000, change0}, {3'b000, e.ch});
            end
        end
    end

    task automatic expect_at(int unsigned c, bit which, string nm,
                             logic [3:0] qv, logic [3:0] rv, logic [3:0] fv);
        exp_t e;
        e.cyc   = c;
        e.which = which;
        e.name  = nm;
        e.q     = qv;
        e.r     = rv;
        e.f     = fv;
        e.ch    = |(rv | fv);
        sb.push_back(e);
    endtask

    // Drive a new level on d and expect q to move exactly L edges later
    // with a single-cycle pulse.
    task automatic step(string nm, logic [3:0] oldv, logic [3:0] newv,
                        logic [3:0] rv, logic [3:0] fv);
        int unsigned c;
        c = cyc;
        d = newv;
        for (int unsigned k = 1; k < L; k++) expect_at(c + k, 0, nm, oldv, 4'h0, 4'h0);
        expect_at(c + L,     0, nm, newv, rv,   fv);
        expect_at(c + L + 1, 0, nm, newv, 4'h0, 4'h0);
        repeat (L + 2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;

        // Reset held with inputs high: outputs pinned to RST_VAL.
        #1;
        rst = 1'b0;
        d   = 4'hF;
        d1  = 4'hF;
        for (int unsigned k = 1; k <= 10; k++) begin
            expect_at(k, 0, "reset_q0", 4'h0, 4'h0, 4'h0);
            expect_at(k, 1, "reset_qA", 4'hA, 4'h0, 4'h0);
        end
        repeat (10) @(negedge clk);

        // Release: no pulses, levels stay at RST_VAL.
        rst = 1'b1;
        d   = 4'h0;
        d1  = 4'hA;
        for (int unsigned k = 11; k <= 16; k++) begin
            expect_at(k, 0, "release_q0", 4'h0, 4'h0, 4'h0);
            expect_at(k, 1, "release_qA", 4'hA, 4'h0, 4'h0);
        end
        repeat (6) @(negedge clk);

        step("step_0101", 4'h0, 4'h5, 4'h5, 4'h0);
        step("fall_0101", 4'h5, 4'h0, 4'h0, 4'h5);

        // Glitch on one channel.
        c = cyc;
`ifdef SYNC_DEBOUNCE_EN
        d = 4'h1;   // 3 cycles: one short of the filter window
        for (int unsigned k = 1; k <= 10; k++) expect_at(c + k, 0, "glitch", 4'h0, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        d = 4'h0;
        repeat (8) @(negedge clk);
`else
        d = 4'h2;   // single-cycle pulse passes straight through
        expect_at(c + 1, 0, "glitch", 4'h0, 4'h0, 4'h0);
        expect_at(c + 2, 0, "glitch", 4'h0, 4'h0, 4'h0);
        expect_at(c + 3, 0, "glitch", 4'h2, 4'h2, 4'h0);
        expect_at(c + 4, 0, "glitch", 4'h0, 4'h0, 4'h2);
        expect_at(c + 5, 0, "glitch", 4'h0, 4'h0, 4'h0);
        expect_at(c + 6, 0, "glitch", 4'h0, 4'h0, 4'h0);
        repeat (1) @(negedge clk);
        d = 4'h0;
        repeat (7) @(negedge clk);
`endif

        step("step_after_glitch", 4'h0, 4'h5, 4'h5, 4'h0);
        step("swap_5_to_A",       4'h5, 4'hA, 4'hA, 4'h5);
        step("clear_A",           4'hA, 4'h0, 4'h0, 4'hA);

        // Reset asserted mid-count, then full latency again after release.
        c = cyc;
        d = 4'hF;
        for (int unsigned k = 1; k <= 3; k++) begin
            if (k == L)      expect_at(c + k, 0, "rst_mid_pre", 4'hF, 4'hF, 4'h0);
            else if (k > L)  expect_at(c + k, 0, "rst_mid_pre", 4'hF, 4'h0, 4'h0);
            else             expect_at(c + k, 0, "rst_mid_pre", 4'h0, 4'h0, 4'h0);
        end
        for (int unsigned k = 4; k <= 7; k++) expect_at(c + k, 0, "rst_mid_held", 4'h0, 4'h0, 4'h0);
        for (int unsigned k = 8; k < L + 7; k++) expect_at(c + k, 0, "rst_mid_post", 4'h0, 4'h0, 4'h0);
        expect_at(c + L + 7, 0, "rst_mid_rise", 4'hF, 4'hF, 4'h0);
        expect_at(c + L + 8, 0, "rst_mid_hold", 4'hF, 4'h0, 4'h0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (L + 2) @(negedge clk);

        step("fall_all", 4'hF, 4'h0, 4'h0, 4'hF);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
